// File: rtl/lagd_mem_bank_arbiter.sv
// Round-robin arbiter sharing one single-ported memory bank between NumReq requesters.
// Grants are combinational; responses retire in issue order through a BankLatency-deep tracker.
module lagd_mem_bank_arbiter #(
  parameter int NumReq      = 2,
  parameter int AddrWidth   = 11,
  parameter int DataWidth   = 64,
  parameter int BankLatency = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0]              req_we_i,
  input  logic [NumReq*DataWidth/8-1:0]  req_be_i,
  input  logic [NumReq*DataWidth-1:0]    req_wdata_i,
  output logic [NumReq-1:0]              rsp_valid_o,
  output logic [DataWidth-1:0]           rsp_rdata_o,
  output logic                           bank_req_o,
  output logic                           bank_we_o,
  output logic [AddrWidth-1:0]           bank_addr_o,
  output logic [DataWidth/8-1:0]         bank_be_o,
  output logic [DataWidth-1:0]           bank_wdata_o,
  input  logic [DataWidth-1:0]           bank_rdata_i,
  output logic                           busy_o
);

  localparam int IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CandWidth = IdxWidth + 1;
  localparam int BeWidth   = DataWidth / 8;
  localparam int LastStage = BankLatency - 1;

  logic [IdxWidth-1:0]  rr_r;
  logic [IdxWidth-1:0]  rr_next_s;
  logic [NumReq-1:0]    valid_s;
  logic [IdxWidth:0]    pick_s;
  logic                 grant_s;
  logic [IdxWidth-1:0]  win_idx_s;

  logic [BankLatency-1:0] pipe_valid_r;
  logic [BankLatency-1:0] pipe_we_r;
  logic [IdxWidth-1:0]    pipe_idx_r [BankLatency];

  // First valid requester at or after start, wrapping modulo NumReq; MSB flags a hit.
  // Scanning from the farthest offset down lets the nearest candidate overwrite the result.
  function automatic logic [IdxWidth:0] rr_pick(input logic [NumReq-1:0]   valid,
                                                input logic [IdxWidth-1:0] start);
    logic [IdxWidth:0]    res;
    logic [CandWidth-1:0] cand;
    res = {CandWidth{1'b0}};
    for (int off = NumReq - 1; off >= 0; off--) begin
      cand = {1'b0, start} + CandWidth'(off);
      if (cand >= CandWidth'(NumReq)) begin
        cand = cand - CandWidth'(NumReq);
      end else begin
        cand = cand;
      end
      if (valid[cand[IdxWidth-1:0]]) begin
        res = {1'b1, cand[IdxWidth-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Requests are invisible while reset is held.
  assign valid_s   = rst_i ? {NumReq{1'b0}} : req_valid_i;
  assign pick_s    = rr_pick(valid_s, rr_r);
  assign grant_s   = pick_s[IdxWidth];
  assign win_idx_s = pick_s[IdxWidth-1:0];

  // Pointer advance: one past the winner, wrapping at NumReq.
  always_comb begin
    rr_next_s = {IdxWidth{1'b0}};
    if (win_idx_s == IdxWidth'(NumReq - 1)) begin
      rr_next_s = {IdxWidth{1'b0}};
    end else begin
      rr_next_s = win_idx_s + {{(IdxWidth-1){1'b0}}, 1'b1};
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_r <= {IdxWidth{1'b0}};
    end else if (grant_s) begin
      rr_r <= rr_next_s;
    end else begin
      rr_r <= rr_r;
    end
  end

  // Grant decode and bank-side mux; everything is zero when nobody wins.
  always_comb begin
    req_ready_o  = {NumReq{1'b0}};
    bank_req_o   = grant_s;
    bank_we_o    = 1'b0;
    bank_addr_o  = {AddrWidth{1'b0}};
    bank_be_o    = {BeWidth{1'b0}};
    bank_wdata_o = {DataWidth{1'b0}};
    for (int i = 0; i < NumReq; i++) begin
      if (grant_s && (win_idx_s == IdxWidth'(i))) begin
        req_ready_o[i] = 1'b1;
        bank_we_o      = req_we_i[i];
        bank_addr_o    = req_addr_i[i*AddrWidth +: AddrWidth];
        bank_be_o      = req_be_i[i*BeWidth +: BeWidth];
        bank_wdata_o   = req_wdata_i[i*DataWidth +: DataWidth];
      end else begin
        req_ready_o[i] = 1'b0;
      end
    end
  end

  // Response tracker: stage 0 captures this cycle's grant, later stages shift.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_valid_r <= {BankLatency{1'b0}};
      pipe_we_r    <= {BankLatency{1'b0}};
      for (int k = 0; k < BankLatency; k++) begin
        pipe_idx_r[k] <= {IdxWidth{1'b0}};
      end
    end else begin
      pipe_valid_r[0] <= grant_s;
      pipe_we_r[0]    <= bank_we_o;
      pipe_idx_r[0]   <= win_idx_s;
      for (int k = 1; k < BankLatency; k++) begin
        pipe_valid_r[k] <= pipe_valid_r[k-1];
        pipe_we_r[k]    <= pipe_we_r[k-1];
        pipe_idx_r[k]   <= pipe_idx_r[k-1];
      end
    end
  end

  // Retire: one-hot valid to the issuing requester, data only for reads.
  always_comb begin
    rsp_valid_o = {NumReq{1'b0}};
    rsp_rdata_o = {DataWidth{1'b0}};
    for (int i = 0; i < NumReq; i++) begin
      if (pipe_valid_r[LastStage] && (pipe_idx_r[LastStage] == IdxWidth'(i))) begin
        rsp_valid_o[i] = 1'b1;
      end else begin
        rsp_valid_o[i] = 1'b0;
      end
    end
    if (pipe_valid_r[LastStage] && !pipe_we_r[LastStage]) begin
      rsp_rdata_o = bank_rdata_i;
    end else begin
      rsp_rdata_o = {DataWidth{1'b0}};
    end
  end

  assign busy_o = (|valid_s) | (|pipe_valid_r);

endmodule

// File: tb/tb_lagd_mem_bank_arbiter.sv
// Directed bench: stimulus pushes expected responses into a queue, a negedge monitor retires them.
module tb_lagd_mem_bank_arbiter;

  localparam int N  = 3;
  localparam int AW = 11;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int L  = 2;

  typedef struct {
    int           due;
    logic [N-1:0] oh;
    logic [DW-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N-1:0]      req_we = '0;
  logic [N*BW-1:0]   req_be = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              bank_req;
  logic              bank_we;
  logic [AW-1:0]     bank_addr;
  logic [BW-1:0]     bank_be;
  logic [DW-1:0]     bank_wdata;
  logic [DW-1:0]     bank_rdata;
  logic              busy;

  logic [AW-1:0] f_addr [N];
  logic          f_we   [N];
  logic [BW-1:0] f_be   [N];
  logic [DW-1:0] f_wd   [N];
  logic [DW-1:0] bank_pipe [L];

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  lagd_mem_bank_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .BankLatency(L)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_be_i(req_be), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
    .bank_be_o(bank_be), .bank_wdata_o(bank_wdata), .bank_rdata_i(bank_rdata),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return 64'hDEAD_BEEF_0000_0000 ^ {53'd0, a};
  endfunction

  // Bank model: returns the address pattern L cycles after every access.
  always @(posedge clk) begin
    bank_pipe[0] <= bank_req ? pattern(bank_addr) : 64'd0;
    for (int k = 1; k < L; k++) bank_pipe[k] <= bank_pipe[k-1];
  end
  assign bank_rdata = bank_pipe[L-1];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic we,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
    f_addr[i] = a; f_we[i] = we; f_be[i] = be; f_wd[i] = wd;
  endtask

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = f_addr[i];
      req_we[i]             = f_we[i];
      req_be[i*BW +: BW]    = f_be[i];
      req_wdata[i*DW +: DW] = f_wd[i];
    end
  endtask

  // One cycle of stimulus with the hand-computed grant; expected response is queued.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] exp_rdy);
    exp_t e;
    int w;
    @(posedge clk);
    #1;
    drive_fields();
    req_valid = v;
    #3;
    check("ready", {61'd0, req_ready}, {61'd0, exp_rdy});
    check("busy", {63'd0, busy}, {63'd0, ((|v) || (q.size() > 0))});
    check("bank_req", {63'd0, bank_req}, {63'd0, (|v)});
    if (exp_rdy != '0) begin
      w = 0;
      for (int i = 0; i < N; i++) if (exp_rdy[i]) w = i;
      check("bank_addr", {53'd0, bank_addr}, {53'd0, f_addr[w]});
      check("bank_we", {63'd0, bank_we}, {63'd0, f_we[w]});
      check("bank_be", {56'd0, bank_be}, {56'd0, f_be[w]});
      check("bank_wdata", bank_wdata, f_wd[w]);
      e.due  = cyc + L;
      e.oh   = exp_rdy;
      e.data = f_we[w] ? 64'd0 : pattern(f_addr[w]);
      q.push_back(e);
    end else if (v == '0) begin
      check("bank_idle", {bank_we, 42'd0, bank_addr, bank_be} | {1'b0, bank_wdata[62:0]}, 64'd0);
    end
  endtask

  // Monitor: retire the queue head when due, otherwise expect silence.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      check("rsp_valid", {61'd0, rsp_valid}, {61'd0, q[0].oh});
      check("rsp_rdata", rsp_rdata, q[0].data);
      void'(q.pop_front());
    end else begin
      check("rsp_idle_valid", {61'd0, rsp_valid}, 64'd0);
      check("rsp_idle_rdata", rsp_rdata, 64'd0);
    end
  end

  initial begin
    for (int i = 0; i < N; i++) set_req(i, 11'h000, 1'b0, 8'hFF, 64'd0);
    drive_fields();
    // reset state, with requests present and ignored
    repeat (2) @(posedge clk);
    #4;
    check("rst_ready", {61'd0, req_ready}, 64'd0);
    check("rst_bank_req", {63'd0, bank_req}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    req_valid = 3'b111;
    #1;
    check("rst_ready_ignored", {61'd0, req_ready}, 64'd0);
    check("rst_bank_req_ignored", {63'd0, bank_req}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 3'b000;

    // single read
    set_req(0, 11'h010, 1'b0, 8'hFF, 64'd0);
    step(3'b001, 3'b001);
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);

    // fresh reset, then two-way contention
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_req(1, 11'h020, 1'b0, 8'hFF, 64'd0);
    step(3'b011, 3'b001);
    step(3'b011, 3'b010);
    step(3'b011, 3'b001);
    step(3'b011, 3'b010);

    // write acknowledge from req1
    set_req(1, 11'h7FF, 1'b1, 8'h0F, 64'h0000_0000_0000_1234);
    step(3'b010, 3'b010);

    // fairness with req2 always valid
    set_req(0, 11'h030, 1'b0, 8'hFF, 64'd0);
    set_req(1, 11'h040, 1'b0, 8'hFF, 64'd0);
    set_req(2, 11'h050, 1'b1, 8'hF0, 64'hAAAA_5555_0F0F_F0F0);
    step(3'b111, 3'b100);
    step(3'b111, 3'b001);
    step(3'b111, 3'b010);
    step(3'b101, 3'b100);
    step(3'b101, 3'b001);
    step(3'b110, 3'b010);
    step(3'b100, 3'b100);

    // full throughput, back-to-back reads from req0
    for (int k = 0; k < 8; k++) begin
      set_req(0, 11'(11'h100 + k), 1'b0, 8'hFF, 64'd0);
      step(3'b001, 3'b001);
    end
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);

    // reset one cycle after a grant: the response must vanish
    set_req(1, 11'h060, 1'b0, 8'hFF, 64'd0);
    step(3'b010, 3'b010);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    req_valid = 3'b111;
    #3;
    check("midrst_ready", {61'd0, req_ready}, 64'd0);
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    rst = 1'b0;
    step(3'b111, 3'b001);
    step(3'b111, 3'b010);
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);

    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses never retired, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
